// File: rtl/synth_midi_pkg.sv
// ---------------------------------------------------------------------------
// synth_midi_pkg
// Shared MIDI constants and voice allocator encodings.
//   - MIDI status nibbles (upper half of the status byte)
//   - Control-change numbers the allocator reacts to
//   - Allocator FSM state and decoded-operation encodings
// ---------------------------------------------------------------------------
package synth_midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_CC       = 4'hB;

    localparam logic [6:0] CC_SUSTAIN       = 7'd64;
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    // Pedal is "down" for controller values 64..127.
    localparam logic [6:0] PEDAL_THRESHOLD = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_APPLY  = 2'd2,
        ST_RETRIG = 2'd3
    } alloc_state_t;

    // Operation latched at event acceptance; drives SCAN/APPLY behaviour.
    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_NOTE_ON  = 3'd1,
        OP_NOTE_OFF = 3'd2,
        OP_PEDAL    = 3'd3,
        OP_ALL_OFF  = 3'd4
    } alloc_op_t;

endpackage

// File: rtl/voice_age_tracker.sv
// ---------------------------------------------------------------------------
// voice_age_tracker
// Holds one note-on age stamp per voice and a free-running stamp counter
// that advances once per note-on assignment. The age of a voice is the
// modular distance (counter - stamp), which stays correct across counter
// wrap as long as no voice is older than 2^AGE_BITS assignments.
// Ports:
//   clk, rst    main clock, asynchronous active-high reset
//   stamp_en    record the counter into stamp[stamp_idx] and advance it
//   stamp_idx   voice receiving the stamp
//   query_idx   voice whose age is reported on age
//   age         (counter - stamp[query_idx]) mod 2^AGE_BITS
// ---------------------------------------------------------------------------
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 8,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stamp_en,
    input  logic [IDX_W-1:0]    stamp_idx,
    input  logic [IDX_W-1:0]    query_idx,
    output logic [AGE_BITS-1:0] age
);

    logic [AGE_BITS-1:0] counter;
    logic [AGE_BITS-1:0] stamps [NUM_VOICES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                stamps[i] <= '0;
            end
        end else if (stamp_en) begin
            stamps[stamp_idx] <= counter;
            counter           <= counter + AGE_BITS'(1);
        end
    end

    assign age = counter - stamps[query_idx];

endmodule

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Assigns MIDI note events to a bank of NUM_VOICES voices. Note-on reuses a
// voice already playing the note, else takes the lowest free voice, else
// steals the oldest voice. Reused/stolen voices get a RETRIG_CYCLES low-gate
// gap so the envelope restarts. Also handles sustain pedal and all-off.
// Ports:
//   clk, rst       main clock, asynchronous active-high reset
//   event_valid    framed MIDI event present
//   event_ready    high only in IDLE
//   event_command  MIDI status byte (channel nibble ignored)
//   event_param1   note / controller number
//   event_param2   velocity / controller value
//   voice_gate     per-voice gate
//   voice_note     per-voice note, voice i at [7i+6:7i]
//   voice_update   one-cycle strobe when a voice note is (re)assigned
//   busy           FSM not in IDLE
// Handshake: an event transfers on a clk edge where event_valid and
// event_ready are both 1; event_ready is high only in IDLE, so events are
// strictly serialized and every accepted event is consumed.
// ---------------------------------------------------------------------------
module voice_allocator
    import synth_midi_pkg::*;
#(
    parameter int NUM_VOICES    = 4,
    parameter int AGE_BITS      = 8,
    parameter int RETRIG_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    event_valid,
    output logic                    event_ready,
    input  logic [7:0]              event_command,
    input  logic [6:0]              event_param1,
    input  logic [6:0]              event_param2,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_update,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(RETRIG_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t state;
    alloc_op_t    op;
    alloc_op_t    op_dec;

    logic [6:0]            key;
    logic                  pedal_new;
    logic                  pedal;
    logic [IDX_W-1:0]      scan_idx;
    logic                  match_found, free_found;
    logic [IDX_W-1:0]      match_idx, free_idx, oldest_idx, target_idx;
    logic [AGE_BITS-1:0]   oldest_age;
    logic                  retrig_pending;
    logic [CNT_W-1:0]      retrig_cnt;
    logic [NUM_VOICES-1:0] gate, sustained, update;
    logic [6:0]            notes [NUM_VOICES];

    // Scan bookkeeping including the voice visited this cycle.
    logic                  match_found_n, free_found_n;
    logic [IDX_W-1:0]      match_idx_n, free_idx_n, oldest_idx_n;
    logic [AGE_BITS-1:0]   oldest_age_n;
    logic [IDX_W-1:0]      target_n;
    logic                  retrig_n;
    logic [AGE_BITS-1:0]   scan_age;
    logic                  stamp_en;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_BITS   (AGE_BITS),
        .IDX_W      (IDX_W)
    ) u_age (
        .clk       (clk),
        .rst       (rst),
        .stamp_en  (stamp_en),
        .stamp_idx (target_n),
        .query_idx (scan_idx),
        .age       (scan_age)
    );

    // Event decode; casez on the whole status byte makes the channel a don't-care.
    always_comb begin
        op_dec = OP_NONE;
        casez (event_command)
            {MIDI_NOTE_ON, 4'b????}:
                op_dec = (event_param2 == 7'd0) ? OP_NOTE_OFF : OP_NOTE_ON;
            {MIDI_NOTE_OFF, 4'b????}:
                op_dec = OP_NOTE_OFF;
            {MIDI_CC, 4'b????}: begin
                if (event_param1 == CC_SUSTAIN)
                    op_dec = OP_PEDAL;
                else if (event_param1 == CC_ALL_SOUND_OFF || event_param1 == CC_ALL_NOTES_OFF)
                    op_dec = OP_ALL_OFF;
            end
            default: op_dec = OP_NONE;
        endcase
    end

    always_comb begin
        match_found_n = match_found;
        match_idx_n   = match_idx;
        free_found_n  = free_found;
        free_idx_n    = free_idx;
        oldest_idx_n  = oldest_idx;
        oldest_age_n  = oldest_age;
        if (!match_found && gate[scan_idx] && notes[scan_idx] == key) begin
            match_found_n = 1'b1;
            match_idx_n   = scan_idx;
        end
        if (!free_found && !gate[scan_idx] && !sustained[scan_idx]) begin
            free_found_n = 1'b1;
            free_idx_n   = scan_idx;
        end
        // Strict '>' keeps the lowest index on equal ages.
        if (scan_idx == '0 || scan_age > oldest_age) begin
            oldest_idx_n = scan_idx;
            oldest_age_n = scan_age;
        end
        if (match_found_n) begin
            target_n = match_idx_n;
            retrig_n = 1'b1;
        end else if (free_found_n) begin
            target_n = free_idx_n;
            retrig_n = 1'b0;
        end else begin
            target_n = oldest_idx_n;
            retrig_n = 1'b1;
        end
    end

    // Stamp lands on the same edge the target is chosen.
    assign stamp_en = (state == ST_SCAN) && (scan_idx == LAST_IDX) && (op == OP_NOTE_ON);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            op             <= OP_NONE;
            key            <= '0;
            pedal_new      <= 1'b0;
            pedal          <= 1'b0;
            scan_idx       <= '0;
            match_found    <= 1'b0;
            free_found     <= 1'b0;
            match_idx      <= '0;
            free_idx       <= '0;
            oldest_idx     <= '0;
            oldest_age     <= '0;
            target_idx     <= '0;
            retrig_pending <= 1'b0;
            retrig_cnt     <= '0;
            gate           <= '0;
            sustained      <= '0;
            update         <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= '0;
            end
        end else begin
            update <= '0;
            case (state)
                ST_IDLE: begin
                    if (event_valid) begin
                        op          <= op_dec;
                        key         <= event_param1;
                        pedal_new   <= (event_param2 >= PEDAL_THRESHOLD);
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        case (op_dec)
                            OP_NOTE_ON, OP_NOTE_OFF: state <= ST_SCAN;
                            OP_PEDAL, OP_ALL_OFF:    state <= ST_APPLY;
                            default:                 state <= ST_IDLE;
                        endcase
                    end
                end
                ST_SCAN: begin
                    match_found <= match_found_n;
                    match_idx   <= match_idx_n;
                    free_found  <= free_found_n;
                    free_idx    <= free_idx_n;
                    oldest_idx  <= oldest_idx_n;
                    oldest_age  <= oldest_age_n;
                    if (scan_idx == LAST_IDX) begin
                        state          <= ST_APPLY;
                        target_idx     <= target_n;
                        retrig_pending <= retrig_n;
                        // Note and strobe change together so the strobe
                        // always loads the new frequency.
                        if (op == OP_NOTE_ON) begin
                            notes[target_n]  <= key;
                            update[target_n] <= 1'b1;
                        end
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                ST_APPLY: begin
                    state <= ST_IDLE;
                    case (op)
                        OP_NOTE_ON: begin
                            sustained[target_idx] <= 1'b0;
                            if (retrig_pending) begin
                                gate[target_idx] <= 1'b0;
                                retrig_cnt       <= CNT_W'(RETRIG_CYCLES - 1);
                                state            <= ST_RETRIG;
                            end else begin
                                gate[target_idx] <= 1'b1;
                            end
                        end
                        OP_NOTE_OFF: begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (gate[i] && notes[i] == key) begin
                                    if (pedal) sustained[i] <= 1'b1;
                                    else       gate[i]      <= 1'b0;
                                end
                            end
                        end
                        OP_PEDAL: begin
                            pedal <= pedal_new;
                            if (pedal && !pedal_new) begin
                                gate      <= gate & ~sustained;
                                sustained <= '0;
                            end
                        end
                        OP_ALL_OFF: begin
                            gate      <= '0;
                            sustained <= '0;
                        end
                        default: ;
                    endcase
                end
                ST_RETRIG: begin
                    if (retrig_cnt == '0) begin
                        gate[target_idx] <= 1'b1;
                        state            <= ST_IDLE;
                    end else begin
                        retrig_cnt <= retrig_cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign voice_note[7*g +: 7] = notes[g];
    end

    assign voice_gate   = gate;
    assign voice_update = update;
    assign event_ready  = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

endmodule
